// File: rtl/c_credit_pkg.sv
// rtl/c_credit_pkg.sv - shared types and helpers for the credit sender
// Contents:
//   state_t          sender FSM state encoding
//   ST_RUN           normal operation, flits may be sent
//   ST_DRAIN         quiesce requested, waiting for all credits to return
//   ST_DRAINED       quiesce complete
//   clogb()          ceil(log2(value)), used to size the credit counter
package c_credit_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN     = 2'd0;
    localparam state_t ST_DRAIN   = 2'd1;
    localparam state_t ST_DRAINED = 2'd2;

    // Number of bits needed to encode 0..value-1; clogb(depth+1) holds 0..depth.
    function automatic int clogb(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/c_credit_sender_if.sv
// rtl/c_credit_sender_if.sv - flit handshake and credit return bundle
// Signals:
//   in_valid   upstream has a flit to send
//   in_ready   sender can accept a flit this cycle
//   send       flit transferred this cycle
//   cred_ret   downstream freed one buffer entry
// Modports:
//   master     upstream / downstream side (drives in_valid, cred_ret)
//   slave      credit sender (drives in_ready, send)
interface c_credit_sender_if;

    logic in_valid;
    logic in_ready;
    logic send;
    logic cred_ret;

    modport master (
        output in_valid,
        output cred_ret,
        input  in_ready,
        input  send
    );

    modport slave (
        input  in_valid,
        input  cred_ret,
        output in_ready,
        output send
    );

endinterface

// File: rtl/c_dff.sv
// rtl/c_dff.sv - enabled register with asynchronous active-low reset
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous reset, active low
//   active   load enable; q holds when 0
//   d        next value
//   q        registered value (reset_value while reset is low)
module c_dff #(
    parameter int               width       = 1,
    parameter logic [width-1:0] reset_value = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= reset_value;
        end else if (active) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/c_credit_sender.sv
// rtl/c_credit_sender.sv - credit-based flow control sender with drain FSM
// Optional feature macro: C_CREDIT_SENDER_RET_REG_EN (registers cred_ret once
// before it updates the count).
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous reset, active low
//   active          register enable; all state holds when 0
//   bus             slave side of c_credit_sender_if (in_valid/in_ready/send/cred_ret)
//   drain_req       request quiesce
//   drained         quiesce complete
//   credits         current credit count (0..depth)
//   no_credits      registered credits == 0
//   one_credit      registered credits == 1
//   all_credits     registered credits == depth
//   error_overflow  credit returned while already full
module c_credit_sender
    import c_credit_pkg::*;
#(
    parameter  int depth      = 8,
    localparam int cred_width = clogb(depth + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    c_credit_sender_if.slave      bus,
    input  logic                  drain_req,
    output logic                  drained,
    output logic [cred_width-1:0] credits,
    output logic                  no_credits,
    output logic                  one_credit,
    output logic                  all_credits,
    output logic                  error_overflow
);

    logic w_ret_eff;
    logic w_ret_pending;

`ifdef C_CREDIT_SENDER_RET_REG_EN
    logic r_ret_q;

    c_dff #(.width(1), .reset_value(1'b0)) u_ret_reg (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .d      (bus.cred_ret),
        .q      (r_ret_q)
    );

    assign w_ret_eff     = r_ret_q;
    // A return sitting in the stage has not reached the count yet, so the
    // drain must not complete while it is there.
    assign w_ret_pending = r_ret_q;
`else
    assign w_ret_eff     = bus.cred_ret;
    assign w_ret_pending = 1'b0;
`endif

    logic [cred_width-1:0] r_credits;
    logic [cred_width-1:0] w_cred_next;
    logic                  r_no_credits;
    logic                  r_one_credit;
    logic                  r_all_credits;
    logic                  w_no_next;
    logic                  w_one_next;
    logic                  w_all_next;
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_in_ready;
    logic                  w_send;
    logic                  w_overflow;

    // in_ready depends only on flops, so no combinational path from
    // in_valid or cred_ret; a return at zero credits cannot be bypassed.
    assign w_in_ready = ~r_no_credits & (r_state == ST_RUN);
    assign w_send     = bus.in_valid & w_in_ready;
    assign w_overflow = w_ret_eff & r_all_credits & ~w_send;

    // Overflowing return is dropped so the count saturates at depth.
    always_comb begin
        w_cred_next = r_credits;
        if (!w_overflow) begin
            w_cred_next = r_credits - cred_width'(w_send) + cred_width'(w_ret_eff);
        end
    end

    // Flags are decoded from the next count and registered alongside it.
    assign w_no_next  = (w_cred_next == '0);
    assign w_one_next = (w_cred_next == cred_width'(1));
    assign w_all_next = (w_cred_next == cred_width'(depth));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (drain_req) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain_req) begin
                    w_state_next = ST_RUN;
                end else if (r_all_credits && !w_ret_pending) begin
                    w_state_next = ST_DRAINED;
                end
            end
            ST_DRAINED: begin
                if (!drain_req) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    c_dff #(.width(cred_width), .reset_value(cred_width'(depth))) u_credits_reg (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .d      (w_cred_next),
        .q      (r_credits)
    );

    c_dff #(.width(1), .reset_value(1'b0)) u_no_reg (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .d      (w_no_next),
        .q      (r_no_credits)
    );

    c_dff #(.width(1), .reset_value(depth == 1)) u_one_reg (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .d      (w_one_next),
        .q      (r_one_credit)
    );

    c_dff #(.width(1), .reset_value(1'b1)) u_all_reg (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .d      (w_all_next),
        .q      (r_all_credits)
    );

    c_dff #(.width(2), .reset_value(ST_RUN)) u_state_reg (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .d      (w_state_next),
        .q      (r_state)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.send       = w_send;
    assign drained        = (r_state == ST_DRAINED);
    assign credits        = r_credits;
    assign no_credits     = r_no_credits;
    assign one_credit     = r_one_credit;
    assign all_credits    = r_all_credits;
    // Without the return stage cred_ret reaches this logic directly, so a
    // return seen while reset holds the count at full must not flag.
    assign error_overflow = w_overflow & reset;

endmodule

// File: tb/tb_c_credit_sender.sv
// tb/tb_c_credit_sender.sv - self-checking bench for c_credit_sender
module tb_c_credit_sender;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef C_CREDIT_SENDER_RET_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int M_RUN     = 0;
    localparam int M_DRAIN   = 1;
    localparam int M_DRAINED = 2;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          active    = 1'b1;
    logic          drain_req = 1'b0;
    logic          drained;
    logic [CW-1:0] credits;
    logic          no_credits;
    logic          one_credit;
    logic          all_credits;
    logic          error_overflow;

    c_credit_sender_if bus_if ();

    c_credit_sender #(.depth(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .bus            (bus_if),
        .drain_req      (drain_req),
        .drained        (drained),
        .credits        (credits),
        .no_credits     (no_credits),
        .one_credit     (one_credit),
        .all_credits    (all_credits),
        .error_overflow (error_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: credit count, drain mode, and returns still in flight.
    int m_cred;
    int m_st;
    bit m_ret_d;
    bit e_ret_eff;
    bit e_in_ready;
    bit e_send;
    bit e_ovf;

    task automatic model_reset();
        m_cred  = DEPTH;
        m_st    = M_RUN;
        m_ret_d = 1'b0;
    endtask

    task automatic model_eval();
`ifdef C_CREDIT_SENDER_RET_REG_EN
        e_ret_eff = m_ret_d;
`else
        e_ret_eff = bus_if.cred_ret;
`endif
        e_in_ready = (m_cred > 0) && (m_st == M_RUN);
        e_send     = bus_if.in_valid && e_in_ready;
        e_ovf      = reset && e_ret_eff && (m_cred == DEPTH) && !e_send;
    endtask

    task automatic model_update();
        bit pend;
        if (!reset) begin
            model_reset();
        end else if (active) begin
            pend = (LAT == 2) && m_ret_d;
            case (m_st)
                M_RUN:   if (drain_req) m_st = M_DRAIN;
                M_DRAIN: begin
                    if (!drain_req) m_st = M_RUN;
                    else if (m_cred == DEPTH && !pend) m_st = M_DRAINED;
                end
                default: if (!drain_req) m_st = M_RUN;
            endcase
            if (e_ovf) begin
                $display("note: credit returned at full count, count held at %0d", DEPTH);
            end else begin
                m_cred = m_cred - int'(e_send) + int'(e_ret_eff);
            end
`ifdef C_CREDIT_SENDER_RET_REG_EN
            m_ret_d = bus_if.cred_ret;
`endif
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        model_eval();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic goto_credits(input int target);
        int budget;
        budget    = 40;
        drain_req = 1'b0;
        while (!(m_cred == target && m_ret_d == 1'b0 && m_st == M_RUN) && budget > 0) begin
            bus_if.in_valid = (m_cred + int'(m_ret_d) > target);
            bus_if.cred_ret = (m_cred + int'(m_ret_d) < target);
            cyc_begin();
            cyc_end();
            budget--;
        end
        bus_if.in_valid = 1'b0;
        bus_if.cred_ret = 1'b0;
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL goto_credits: credits=%0d required=%0d", credits, target);
        end
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.cred_ret = 1'b1;
        @(negedge clk);
        checks += 7;
        if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL reset_credits: got %0d want %0d", credits, DEPTH); end
        if (all_credits !== 1'b1)   begin errors++; $display("FAIL reset_all: got %b want 1", all_credits); end
        if (no_credits !== 1'b0)    begin errors++; $display("FAIL reset_no: got %b want 0", no_credits); end
        if (one_credit !== 1'b0)    begin errors++; $display("FAIL reset_one: got %b want 0", one_credit); end
        if (drained !== 1'b0)       begin errors++; $display("FAIL reset_drained: got %b want 0", drained); end
        if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready); end
        if (error_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", error_overflow); end
        @(posedge clk);
        model_reset();
        bus_if.cred_ret = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_fill();
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc_begin();
            checks += 3;
            if (bus_if.send !== 1'b1) begin errors++; $display("FAIL fill_send[%0d]: got %b want 1", i, bus_if.send); end
            if (credits !== CW'(DEPTH - i)) begin errors++; $display("FAIL fill_credits[%0d]: got %0d want %0d", i, credits, DEPTH - i); end
            if (one_credit !== (i == DEPTH - 1)) begin errors++; $display("FAIL fill_one[%0d]: got %b want %b", i, one_credit, i == DEPTH - 1); end
            cyc_end();
        end
        cyc_begin();
        checks += 4;
        if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL fill_empty_ready: got %b want 0", bus_if.in_ready); end
        if (no_credits !== 1'b1)      begin errors++; $display("FAIL fill_empty_no: got %b want 1", no_credits); end
        if (credits !== '0)           begin errors++; $display("FAIL fill_empty_credits: got %0d want 0", credits); end
        if (bus_if.send !== 1'b0)     begin errors++; $display("FAIL fill_empty_send: got %b want 0", bus_if.send); end
        cyc_end();
    endtask

    task automatic test_no_bypass();
        bus_if.in_valid = 1'b1;
        bus_if.cred_ret = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            cyc_begin();
            checks += 2;
            if (bus_if.in_ready !== (k == LAT)) begin errors++; $display("FAIL bypass_ready[t+%0d]: got %b want %b", k, bus_if.in_ready, k == LAT); end
            if (bus_if.send !== (k == LAT))     begin errors++; $display("FAIL bypass_send[t+%0d]: got %b want %b", k, bus_if.send, k == LAT); end
            cyc_end();
            bus_if.cred_ret = 1'b0;
        end
        cyc_begin();
        checks += 2;
        if (credits !== '0)      begin errors++; $display("FAIL bypass_credits: got %0d want 0", credits); end
        if (no_credits !== 1'b1) begin errors++; $display("FAIL bypass_no: got %b want 1", no_credits); end
        cyc_end();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic test_simultaneous();
        goto_credits(2);
        bus_if.in_valid = 1'b1;
        bus_if.cred_ret = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc_begin();
            checks += 3;
            if (credits !== CW'(m_cred)) begin errors++; $display("FAIL simul_credits[%0d]: got %0d want %0d", k, credits, m_cred); end
            if (bus_if.send !== 1'b1)    begin errors++; $display("FAIL simul_send[%0d]: got %b want 1", k, bus_if.send); end
            if (error_overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow[%0d]: got %b want 0", k, error_overflow); end
            cyc_end();
        end
        bus_if.in_valid = 1'b0;
        bus_if.cred_ret = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    task automatic test_drain();
        int t_all;
        int t_drn;
        t_all = -1;
        t_drn = -1;
        goto_credits(1);
        drain_req = 1'b1;
        cyc_begin();
        checks++;
        if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL drain_req_cycle_ready: got %b want 1", bus_if.in_ready); end
        cyc_end();
        bus_if.in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus_if.cred_ret = (k < DEPTH - 1);
            cyc_begin();
            checks += 2;
            if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL drain_ready[%0d]: got %b want 0", k, bus_if.in_ready); end
            if (bus_if.send !== 1'b0)     begin errors++; $display("FAIL drain_send[%0d]: got %b want 0", k, bus_if.send); end
            if (all_credits === 1'b1 && t_all < 0) t_all = k;
            if (drained === 1'b1 && t_drn < 0) t_drn = k;
            cyc_end();
        end
        bus_if.cred_ret = 1'b0;
        checks += 3;
        if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL drain_credits: got %0d want %0d", credits, DEPTH); end
        if (t_all < 0)              begin errors++; $display("FAIL drain_all_seen: got never want set"); end
        if (t_drn !== t_all + 1)    begin errors++; $display("FAIL drain_latency: drained at %0d want %0d", t_drn, t_all + 1); end
        drain_req = 1'b0;
        cyc_begin();
        checks++;
        if (drained !== 1'b1) begin errors++; $display("FAIL drain_release_hold: got %b want 1", drained); end
        cyc_end();
        cyc_begin();
        checks += 3;
        if (drained !== 1'b0)         begin errors++; $display("FAIL drain_release_drained: got %b want 0", drained); end
        if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL drain_release_ready: got %b want 1", bus_if.in_ready); end
        if (bus_if.send !== 1'b1)     begin errors++; $display("FAIL drain_release_send: got %b want 1", bus_if.send); end
        cyc_end();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic test_drain_full();
        goto_credits(DEPTH);
        drain_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc_begin();
            checks++;
            if (drained !== (k == 2)) begin errors++; $display("FAIL drain_full[%0d]: got %b want %b", k, drained, k == 2); end
            cyc_end();
        end
        drain_req = 1'b0;
        cyc_begin();
        cyc_end();
        cyc_begin();
        checks++;
        if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL drain_full_release: got %b want 1", bus_if.in_ready); end
        cyc_end();
    endtask

    task automatic test_overflow();
        int seen;
        seen = 0;
        goto_credits(DEPTH);
        bus_if.cred_ret = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            cyc_begin();
            checks += 2;
            if (error_overflow !== (k == LAT - 1)) begin errors++; $display("FAIL overflow_flag[%0d]: got %b want %b", k, error_overflow, k == LAT - 1); end
            if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL overflow_credits[%0d]: got %0d want %0d", k, credits, DEPTH); end
            if (error_overflow === 1'b1) seen++;
            cyc_end();
            bus_if.cred_ret = 1'b0;
        end
        checks += 2;
        if (seen !== 1)          begin errors++; $display("FAIL overflow_count: got %0d want 1", seen); end
        if (all_credits !== 1'b1) begin errors++; $display("FAIL overflow_all: got %b want 1", all_credits); end
    endtask

    task automatic test_reset_mid();
        goto_credits(2);
        bus_if.in_valid = 1'b1;
        bus_if.cred_ret = 1'b1;
        cyc_begin();
        cyc_end();
        reset = 1'b0;
        cyc_begin();
        checks += 3;
        if (credits !== CW'(DEPTH))   begin errors++; $display("FAIL midreset_credits: got %0d want %0d", credits, DEPTH); end
        if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", bus_if.in_ready); end
        if (error_overflow !== 1'b0)  begin errors++; $display("FAIL midreset_overflow: got %b want 0", error_overflow); end
        cyc_end();
        bus_if.in_valid = 1'b0;
        bus_if.cred_ret = 1'b0;
        reset = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            cyc_begin();
            checks += 2;
            if (credits !== CW'(DEPTH))  begin errors++; $display("FAIL midreset_after_credits[%0d]: got %0d want %0d", k, credits, DEPTH); end
            if (error_overflow !== 1'b0) begin errors++; $display("FAIL midreset_after_overflow[%0d]: got %b want 0", k, error_overflow); end
            cyc_end();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            active          = ($urandom_range(9) != 0);
            bus_if.in_valid = $urandom_range(1);
            bus_if.cred_ret = (($urandom_range(2) == 0) && (m_cred + int'(m_ret_d) < DEPTH))
                              || ($urandom_range(49) == 0);
            if ($urandom_range(19) == 0) drain_req = ~drain_req;
            cyc_begin();
            checks += 8;
            if (bus_if.in_ready !== e_in_ready)      begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, bus_if.in_ready, e_in_ready); end
            if (bus_if.send !== e_send)              begin errors++; $display("FAIL rnd_send[%0d]: got %b want %b", n, bus_if.send, e_send); end
            if (credits !== CW'(m_cred))             begin errors++; $display("FAIL rnd_credits[%0d]: got %0d want %0d", n, credits, m_cred); end
            if (no_credits !== (m_cred == 0))        begin errors++; $display("FAIL rnd_no[%0d]: got %b want %b", n, no_credits, m_cred == 0); end
            if (one_credit !== (m_cred == 1))        begin errors++; $display("FAIL rnd_one[%0d]: got %b want %b", n, one_credit, m_cred == 1); end
            if (all_credits !== (m_cred == DEPTH))   begin errors++; $display("FAIL rnd_all[%0d]: got %b want %b", n, all_credits, m_cred == DEPTH); end
            if (drained !== (m_st == M_DRAINED))     begin errors++; $display("FAIL rnd_drained[%0d]: got %b want %b", n, drained, m_st == M_DRAINED); end
            if (error_overflow !== e_ovf)            begin errors++; $display("FAIL rnd_overflow[%0d]: got %b want %b", n, error_overflow, e_ovf); end
            cyc_end();
        end
        active          = 1'b1;
        drain_req       = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.cred_ret = 1'b0;
    endtask

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.cred_ret = 1'b0;
        model_reset();
        test_reset();
        test_fill();
        test_no_bypass();
        test_simultaneous();
        test_drain();
        test_drain_full();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/c_credit_sender.md
C_CREDIT_SENDER -- requirements
Module: c_credit_sender

Interface
REQ-001 Parameter depth, default 8, downstream buffer entries (credits); legal range >=2.
REQ-002 Localparam cred_width = clogb(depth+1), wide enough to hold 0..depth.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-006 active  in  1  register enable; when 0, all state holds.
REQ-007 in_valid  in  1  upstream has a flit to send.
REQ-008 in_ready  out  1  flit may be sent this cycle.
REQ-009 send  out  1  flit transferred this cycle (in_valid & in_ready).
REQ-010 cred_ret  in  1  downstream freed one entry.
REQ-011 drain_req  in  1  request quiesce: stop sending, wait for all credits back.
REQ-012 drained  out  1  quiesce complete.
REQ-013 credits  out  cred_width  current credit count.
REQ-014 no_credits / one_credit / all_credits  out  1 each  registered count==0 / ==1 / ==depth.
REQ-015 error_overflow  out  1  credit returned while count==depth.

Function
REQ-016 Count update: credits_next = credits - send + ret_eff; ret_eff is cred_ret (or its registered copy, REQ-029).
REQ-017 send and ret_eff in the same cycle leave credits unchanged.
REQ-018 no_credits, one_credit, all_credits are flops computed from next-count logic, never decoded from credits after the register.
REQ-019 in_ready = ~no_credits & (state==RUN); combinational from flops only, so it has no path from in_valid or cred_ret.
REQ-020 No bypass: at credits==0 with cred_ret asserted, in_ready stays 0 that cycle and rises the next cycle.
REQ-021 Sending the last credit: credits 1 -> 0 and no_credits=1 on the next cycle; in_ready=0 until a return takes effect.
REQ-022 FSM states RUN, DRAIN, DRAINED.
REQ-023 RUN -> DRAIN when drain_req=1, including when all_credits is already 1.
REQ-024 DRAIN -> DRAINED when all_credits=1 and no return is pending in the REQ-029 stage.
REQ-025 DRAINED -> RUN when drain_req=0.
REQ-026 DRAIN or DRAINED with drain_req=0: go to RUN.
REQ-027 drained = (state==DRAINED); in_ready=0 in DRAIN and DRAINED; returns are still counted in every state.
REQ-028 error_overflow = ret_eff & all_credits & ~send.
  - On overflow the count saturates at depth.
  - Simulation-only $display message on overflow.

Reset
REQ-029 While reset=0:
  - credits=depth, all_credits=1, no_credits=0, one_credit=(depth==1).
  - State RUN, drained=0, in_ready=1, error_overflow=0, return stage cleared.
  - Reset asserted mid-operation discards in-flight returns; the count restarts at depth.

Configuration
REQ-030 With macro C_CREDIT_SENDER_RET_REG_EN defined:
  - cred_ret is registered once; ret_eff is the registered copy.
  - Returns take effect 2 cycles after cred_ret; the count is visible 2 cycles after.
REQ-031 Without the macro: ret_eff = cred_ret; the count is visible 1 cycle after.

Structure
REQ-032 Package c_credit_pkg SHALL hold:
  - state typedef (RUN, DRAIN, DRAINED).
  - cred_width helper function.
REQ-033 All registers SHALL use the existing c_dff with async active-low reset; no new sub-module.

Verification (depth=4, macro undefined unless stated)
REQ-034 Reset release, in_valid held 1: send=1 for 4 cycles; credits 4,3,2,1,0; then in_ready=0, no_credits=1.
REQ-035 credits=0, cred_ret pulse at cycle t: in_ready=0 at t, 1 at t+1; send at t+1 gives credits=0 at t+2.
REQ-036 credits=2, send and cred_ret together for 3 cycles: credits stays 2, error_overflow=0.
REQ-037 Drain with credits=1:
  - drain_req=1: in_ready=0 next cycle.
  - 3 returns bring credits to 4; drained=1 the cycle after all_credits=1.
  - drain_req=0: RUN and in_ready=1 next cycle.
REQ-038 credits=4, cred_ret=1: error_overflow=1 that cycle; credits stays 4.
REQ-039 Macro defined, credits=0, cred_ret at t: in_ready=1 at t+2, not at t+1.
  - Drain in progress: drained waits for the pipeline to empty.
